// File: rtl/mem_access.sv
// Multi-cycle RV32I data-memory access unit: latches a load/store request and commits it LATENCY cycles later.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN turns misaligned half/word accesses into no-ops that flag misaligned.
module mem_access #(
   parameter int LATENCY     = 2,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enabled,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        completed,
   output logic [31:0] rdata,
   output logic        misaligned
);

   localparam int         AW     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic              r_is_load;
   logic              r_is_store;
   logic [2:0]        r_funct3;
   logic [AW+1:0]     r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_mem [DEPTH_WORDS];
   logic [31:0]       r_rdata;
   logic              r_misaligned;
   logic              r_completed;

   logic              w_accept;
   logic              w_commit;
   logic [AW-1:0]     w_word_idx;
   logic [31:0]       w_rd_word;
   logic [31:0]       w_rd_shift;
   logic [15:0]       w_rd_half;
   logic              w_is_half;
   logic              w_is_word;
   logic              w_st_valid;
   logic              w_ld_valid;
   logic              w_misal;
   logic              w_do_write;
   logic [3:0]        w_be;
   logic [31:0]       w_wr_data;
   logic [31:0]       w_ld_data;
   logic              w_unused;

   assign w_unused = ^{addr[31:AW+2]};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; even LATENCY=1 spends one cycle in WAIT so completion lands at N+LATENCY
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (enabled) begin
               w_accept    = 1'b1;
               w_state_nxt = S_WAIT;
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_commit    = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Request latch and latency counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= 4'd0;
         r_is_load  <= 1'b0;
         r_is_store <= 1'b0;
         r_funct3   <= 3'd0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
      end else if (w_accept) begin
         r_cnt      <= LAT_M1;
         r_is_load  <= is_load;
         r_is_store <= is_store;
         r_funct3   <= funct3;
         r_addr     <= addr[AW+1:0];
         r_wdata    <= wdata;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Access decode: a store wins when both is_load and is_store are set
   always_comb begin
      w_word_idx = r_addr[AW+1:2];
      w_rd_word  = r_mem[w_word_idx];
      w_rd_shift = w_rd_word >> {r_addr[1:0], 3'b000};
      w_rd_half  = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      w_is_half  = (r_funct3[1:0] == 2'b01);
      w_is_word  = (r_funct3 == 3'b010);
      w_st_valid = r_is_store && (r_funct3 == 3'b000 || r_funct3 == 3'b001 || r_funct3 == 3'b010);
      w_ld_valid = r_is_load && !r_is_store &&
                   (r_funct3 == 3'b000 || r_funct3 == 3'b001 || r_funct3 == 3'b010 ||
                    r_funct3 == 3'b100 || r_funct3 == 3'b101);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      w_misal = (w_st_valid || w_ld_valid) &&
                ((w_is_half && r_addr[0]) || (w_is_word && (r_addr[1:0] != 2'b00)));
`else
      w_misal = 1'b0;
`endif
      w_do_write = w_commit && w_st_valid && !w_misal;
   end

   // Store lane enables and replicated write data
   always_comb begin
      w_be      = 4'b0000;
      w_wr_data = r_wdata;
      case (r_funct3)
         3'b000: begin
            w_be      = 4'b0001 << r_addr[1:0];
            w_wr_data = {4{r_wdata[7:0]}};
         end
         3'b001: begin
            w_be      = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wr_data = {2{r_wdata[15:0]}};
         end
         3'b010: begin
            w_be      = 4'b1111;
            w_wr_data = r_wdata;
         end
         default: begin
            w_be      = 4'b0000;
            w_wr_data = r_wdata;
         end
      endcase
   end

   // Load extraction and extension
   always_comb begin
      w_ld_data = 32'd0;
      if (w_ld_valid && !w_misal) begin
         case (r_funct3)
            3'b000:  w_ld_data = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_rd_half[15]}}, w_rd_half};
            3'b010:  w_ld_data = w_rd_word;
            3'b100:  w_ld_data = {24'd0, w_rd_shift[7:0]};
            3'b101:  w_ld_data = {16'd0, w_rd_half};
            default: w_ld_data = 32'd0;
         endcase
      end else begin
         w_ld_data = 32'd0;
      end
   end

   // Memory write at the commit edge; reset aborts a pending store and never clears contents
   always_ff @(posedge clk) begin
      if (!rst && w_do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_word_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
         end
      end
   end

   // Result registers: rdata/misaligned change only at commit, completed follows DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata      <= 32'd0;
         r_misaligned <= 1'b0;
         r_completed  <= 1'b0;
      end else begin
         if (w_commit) begin
            r_rdata      <= w_ld_data;
            r_misaligned <= w_misal;
         end
         r_completed <= (w_state_nxt == S_DONE);
      end
   end

   assign completed  = r_completed;
   assign rdata      = r_rdata;
   assign misaligned = r_misaligned;

endmodule
